// File: rtl/ssd_pkg.sv
// Shared types and constants for the binary-to-seven-segment encoder.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_t;

  localparam int VAL_W   = 14;
  localparam int MAX_VAL = 9999;
  localparam int BCD_W   = 16;
  localparam int SR_W    = BCD_W + VAL_W;
  localparam int CNT_W   = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  // Index 0 sits in the least significant slice, so SEG_TABLE[d] is digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Non-decimal nibbles cannot come out of the converter; blank them anyway.
  function automatic logic [6:0] digitPattern(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) begin
        pattern = SEG_TABLE[i];
      end
    end
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern, with a
// blank override used for leading-zero suppression.
module bcd_to_seg7
  import ssd_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the digit so suppressed positions go fully dark.
  always_comb begin
    seg_o = blank_i ? SEG_BLANK : digitPattern(bcd_i);
  end

endmodule

// File: rtl/bin_to_ssd_encoder.sv
// Binary ticket number to four registered seven-segment digits.
// A sequential double-dabble engine builds the BCD digits over VAL_W clocks,
// then one ENCODE cycle latches all four patterns together so the display
// never shows a partially converted value.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on
// seg3..seg1 (seg0 always shows a digit).
module bin_to_ssd_encoder
  import ssd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [6:0]       seg0,
  output logic [6:0]       seg1,
  output logic [6:0]       seg2,
  output logic [6:0]       seg3
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  shiftReg_q, shiftReg_d;
  logic             ovfPend_q, ovfPend_d;
  logic [3:0][6:0]  seg_q, seg_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [3:0][3:0]  bcdDigit;
  logic [3:0]       digitBlank;
  logic [3:0][6:0]  digitSeg;
  logic [SR_W-1:0]  adjusted;

  // State register; reset drops any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load only starts a conversion from IDLE, ENCODE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Digit nibbles live in the upper part of the combined shift register.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcdDigit[i] = shiftReg_q[VAL_W + 4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero only if it and every higher digit are zero.
  always_comb begin
    digitBlank    = '0;
    digitBlank[3] = (bcdDigit[3] == 4'd0);
    digitBlank[2] = digitBlank[3] && (bcdDigit[2] == 4'd0);
    digitBlank[1] = digitBlank[2] && (bcdDigit[1] == 4'd0);
  end
`else
  // Every digit is always shown, zeros included.
  always_comb begin
    digitBlank = '0;
  end
`endif

  for (genvar g = 0; g < 4; g++) begin : gen_digit
    bcd_to_seg7 u_bcd_to_seg7 (
      .bcd_i   (bcdDigit[g]),
      .blank_i (digitBlank[g]),
      .seg_o   (digitSeg[g])
    );
  end

  // Double-dabble correction: bump any nibble >= 5 by 3 before the next shift.
  always_comb begin
    adjusted = shiftReg_q;
    for (int i = 0; i < 4; i++) begin
      if (adjusted[VAL_W + 4*i +: 4] >= 4'd5) begin
        adjusted[VAL_W + 4*i +: 4] = adjusted[VAL_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath and output next values; segments and overflow only move in ENCODE.
  always_comb begin
    cnt_d      = cnt_q;
    shiftReg_d = shiftReg_q;
    ovfPend_d  = ovfPend_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    done_d     = (state_q == ENCODE);
    busy_d     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (load) begin
          shiftReg_d = {{BCD_W{1'b0}}, value_in};
          cnt_d      = '0;
          ovfPend_d  = (value_in > VAL_W'(MAX_VAL));
        end
      end
      SHIFT: begin
        shiftReg_d = {adjusted[SR_W-2:0], 1'b0};
        cnt_d      = cnt_q + 1'b1;
      end
      ENCODE: begin
        overflow_d = ovfPend_q;
        for (int i = 0; i < 4; i++) begin
          seg_d[i] = ovfPend_q ? SEG_DASH : digitSeg[i];
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers; reset blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      shiftReg_q <= '0;
      ovfPend_q  <= 1'b0;
      seg_q      <= {4{SEG_BLANK}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shiftReg_q <= shiftReg_d;
      ovfPend_q  <= ovfPend_d;
      seg_q      <= seg_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign seg0     = seg_q[0];
  assign seg1     = seg_q[1];
  assign seg2     = seg_q[2];
  assign seg3     = seg_q[3];

endmodule

// File: tb/tb_bin_to_ssd_encoder.sv
// Directed bench for bin_to_ssd_encoder with hand-computed digit patterns.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_bin_to_ssd_encoder;

  localparam logic [6:0] P0    = 7'b0000001;
  localparam logic [6:0] P1    = 7'b1001111;
  localparam logic [6:0] P2    = 7'b0010010;
  localparam logic [6:0] P3    = 7'b0000110;
  localparam logic [6:0] P4    = 7'b1001100;
  localparam logic [6:0] P5    = 7'b0100100;
  localparam logic [6:0] P9    = 7'b0000100;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD0 = BLANK;
`else
  localparam logic [6:0] LEAD0 = P0;
`endif

  logic        clock;
  logic        reset;
  logic [13:0] valueIn;
  logic        load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [6:0]  seg0, seg1, seg2, seg3;

  int          testCount;
  int          failCount;
  logic [6:0]  prevSeg0;

  bin_to_ssd_encoder dut (
    .clk      (clock),
    .rst      (reset),
    .value_in (valueIn),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Loads value v at edge 0 and checks busy/done/segments through edge 16.
  // If ignEdge is in 1..16, load is pulsed with ignVal at that edge.
  task automatic applyStimulus(input logic [13:0] v, input int ignEdge, input logic [13:0] ignVal,
                               input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1,
                               input logic [6:0] e0, input logic eOvf);
    @(negedge clock);
    valueIn = v;
    load    = 1'b1;
    @(posedge clock);
    #2;
    load = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clock);
      load    = (e == ignEdge);
      valueIn = (e == ignEdge) ? ignVal : v;
      @(posedge clock);
      #2;
      load = 1'b0;
      if (e <= 14) begin
        checkOutput($sformatf("busy@%0d", e), 32'(busy), 32'd1);
        checkOutput($sformatf("done@%0d", e), 32'(done), 32'd0);
        if (e == 14) begin
          checkOutput("seg0 held", 32'(seg0), 32'(prevSeg0));
        end
      end else if (e == 15) begin
        checkOutput("done@15", 32'(done), 32'd1);
        checkOutput("busy@15", 32'(busy), 32'd1);
        checkOutput("seg3", 32'(seg3), 32'(e3));
        checkOutput("seg2", 32'(seg2), 32'(e2));
        checkOutput("seg1", 32'(seg1), 32'(e1));
        checkOutput("seg0", 32'(seg0), 32'(e0));
        checkOutput("overflow", 32'(overflow), 32'(eOvf));
      end else begin
        checkOutput("done@16", 32'(done), 32'd0);
        checkOutput("busy@16", 32'(busy), 32'd0);
        checkOutput("seg0 hold@16", 32'(seg0), 32'(e0));
      end
    end
    prevSeg0 = e0;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    prevSeg0  = BLANK;
    reset     = 1'b1;
    load      = 1'b0;
    valueIn   = '0;
    #3;
    checkOutput("reset seg0", 32'(seg0), 32'(BLANK));
    checkOutput("reset seg3", 32'(seg3), 32'(BLANK));
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    $display("[TB] value 1234");
    applyStimulus(14'd1234, 0, 14'd0, P1, P2, P3, P4, 1'b0);
    $display("[TB] value 0");
    applyStimulus(14'd0, 0, 14'd0, LEAD0, LEAD0, LEAD0, P0, 1'b0);
    $display("[TB] value 9999");
    applyStimulus(14'd9999, 0, 14'd0, P9, P9, P9, P9, 1'b0);
    $display("[TB] value 10000");
    applyStimulus(14'd10000, 0, 14'd0, DASH, DASH, DASH, DASH, 1'b1);
    $display("[TB] value 42 with ignored load of 7777");
    applyStimulus(14'd42, 5, 14'd7777, LEAD0, LEAD0, P4, P2, 1'b0);
    $display("[TB] value 305");
    applyStimulus(14'd305, 0, 14'd0, LEAD0, P3, P0, P5, 1'b0);

    $display("[TB] value 5678 aborted by reset");
    @(negedge clock);
    valueIn = 14'd5678;
    load    = 1'b1;
    @(posedge clock);
    #2;
    load = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    checkOutput("busy before abort", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort seg0", 32'(seg0), 32'(BLANK));
    checkOutput("abort seg2", 32'(seg2), 32'(BLANK));
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #2;
      checkOutput("abort no done", 32'(done), 32'd0);
    end
    @(negedge clock);
    reset    = 1'b0;
    prevSeg0 = BLANK;
    repeat (8) begin
      @(posedge clock);
      #2;
      checkOutput("idle no done", 32'(done), 32'd0);
    end
    $display("[TB] value 5 after reset");
    applyStimulus(14'd5, 0, 14'd0, LEAD0, LEAD0, LEAD0, P5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
